// File: rtl/thunderbird_pkg.sv
// Shared types and helpers for the sequential ThunderBird turn-light controller.
// The state enum is paired with a separate step counter k in the top level.
package thunderbird_pkg;

    localparam int MAX_LAMPS = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEQ_L,
        ST_SEQ_R,
        ST_HAZ_ON,
        ST_HAZ_OFF
    } state_e;

    function automatic int step_width(input int lamps);
        return $clog2(lamps + 1);
    endfunction

    // Low k bits set; k=0 gives an all-zero mask.
    function automatic logic [MAX_LAMPS-1:0] thermo_mask(input int unsigned k);
        logic [MAX_LAMPS-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_LAMPS; i++) begin
            if (i < k) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle step strobe every TICK_DIV clocks.
// With TICK_DIV=1 the counter stays at zero and the strobe is permanently high.
module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic RESET_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!RESET_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/thunderbird_lights_seq.sv
// Turn/hazard/brake lamp sequencer: the FSM advances only on prescaler steps,
// while the lamp banks are re-decoded every clock so Brake responds at once.
module thunderbird_lights_seq
    import thunderbird_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             RESET_n,
    input  logic             TurnLeft,
    input  logic             TurnRight,
    input  logic             Hazard,
    input  logic             Brake,
    output logic [LAMPS-1:0] Left,
    output logic [LAMPS-1:0] Right,
    output logic             Tick
);

    localparam int SW = step_width(LAMPS);

    state_e           state_q, state_d;
    logic [SW-1:0]    k_q, k_d;
    logic [LAMPS-1:0] left_q, left_d;
    logic [LAMPS-1:0] right_q, right_d;
    logic             tick_q;
    logic             tick_int;
    logic             haz;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .RESET_n(RESET_n),
        .tick   (tick_int)
    );

    // Both turn stalks at once is deliberately treated as a hazard request.
    assign haz = Hazard | (TurnLeft & TurnRight);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        if (tick_int) begin
            case (state_q)
                ST_IDLE, ST_HAZ_OFF: begin
                    k_d = '0;
                    if (haz) begin
                        state_d = ST_HAZ_ON;
                    end else if (TurnLeft) begin
                        state_d = ST_SEQ_L;
                        k_d     = SW'(1);
                    end else if (TurnRight) begin
                        state_d = ST_SEQ_R;
                        k_d     = SW'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SEQ_L: begin
                    if (haz) begin
                        state_d = ST_HAZ_ON;
                        k_d     = '0;
                    end else if (!TurnLeft || k_q == SW'(LAMPS)) begin
                        state_d = ST_IDLE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + SW'(1);
                    end
                end
                ST_SEQ_R: begin
                    if (haz) begin
                        state_d = ST_HAZ_ON;
                        k_d     = '0;
                    end else if (!TurnRight || k_q == SW'(LAMPS)) begin
                        state_d = ST_IDLE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + SW'(1);
                    end
                end
                ST_HAZ_ON: begin
                    state_d = ST_HAZ_OFF;
                    k_d     = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    k_d     = '0;
                end
            endcase
        end
    end

    // Decode from next state so lamps change on the same edge as the state.
    always_comb begin
        left_d  = Brake ? '1 : '0;
        right_d = Brake ? '1 : '0;
        case (state_d)
            ST_SEQ_L:  left_d  = LAMPS'(thermo_mask(32'(k_d)));
            ST_SEQ_R:  right_d = LAMPS'(thermo_mask(32'(k_d)));
            ST_HAZ_ON: begin
                left_d  = '1;
                right_d = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RESET_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            left_q  <= '0;
            right_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            left_q  <= left_d;
            right_q <= right_d;
            tick_q  <= tick_int;
        end
    end

    assign Left  = left_q;
    assign Right = right_q;
    assign Tick  = tick_q;

endmodule

// File: tb/tb_thunderbird_lights_seq.sv
// Directed bench: a vector table walked one animation step at a time, followed
// by hand-written multi-cycle sequences and a LAMPS=5 / TICK_DIV=1 instance.
module tb_thunderbird_lights_seq;

    logic       clk = 1'b0;
    logic       RESET_n;
    logic       TurnLeft, TurnRight, Hazard, Brake;
    logic [2:0] Left, Right;
    logic       Tick;

    logic       rst5_n, tl5;
    logic [4:0] Left5, Right5;
    logic       Tick5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    thunderbird_lights_seq #(.LAMPS(3), .TICK_DIV(4)) dut (
        .clk      (clk),
        .RESET_n  (RESET_n),
        .TurnLeft (TurnLeft),
        .TurnRight(TurnRight),
        .Hazard   (Hazard),
        .Brake    (Brake),
        .Left     (Left),
        .Right    (Right),
        .Tick     (Tick)
    );

    thunderbird_lights_seq #(.LAMPS(5), .TICK_DIV(1)) dut5 (
        .clk      (clk),
        .RESET_n  (rst5_n),
        .TurnLeft (tl5),
        .TurnRight(1'b0),
        .Hazard   (1'b0),
        .Brake    (1'b0),
        .Left     (Left5),
        .Right    (Right5),
        .Tick     (Tick5)
    );

    typedef struct {
        logic       tl;
        logic       tr;
        logic       hz;
        logic       br;
        logic [2:0] el;
        logic [2:0] er;
    } vec_t;

    vec_t vecs [20];

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic tl, input logic tr, input logic hz, input logic br);
        TurnLeft  = tl;
        TurnRight = tr;
        Hazard    = hz;
        Brake     = br;
    endtask

    task automatic do_reset();
        RESET_n = 1'b0;
        wait_edges(1);
        RESET_n = 1'b1;
    endtask

    initial begin
        // tl tr hz br -> expected Left/Right after the next step edge
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 3'b000};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 3'b111};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 3'b001};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 3'b011};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 3'b111};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 3'b111};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 3'b001};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 3'b111};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 3'b111};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 3'b111};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 3'b111};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 3'b111};

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst5_n  = 1'b0;
        tl5     = 1'b0;
        RESET_n = 1'b0;
        wait_edges(2);
        check("reset_left", 32'(Left), 32'h0);
        check("reset_right", 32'(Right), 32'h0);
        check("reset_tick", 32'(Tick), 32'h0);
        RESET_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].tl, vecs[i].tr, vecs[i].hz, vecs[i].br);
            wait_edges(3);
            check($sformatf("vec%0d_tick_low", i), 32'(Tick), 32'h0);
            wait_edges(1);
            $display("vec %0d: tl=%b tr=%b hz=%b br=%b -> Left=%b Right=%b Tick=%b",
                     i, vecs[i].tl, vecs[i].tr, vecs[i].hz, vecs[i].br, Left, Right, Tick);
            check($sformatf("vec%0d_left", i), 32'(Left), 32'(vecs[i].el));
            check($sformatf("vec%0d_right", i), 32'(Right), 32'(vecs[i].er));
            check($sformatf("vec%0d_tick", i), 32'(Tick), 32'h1);
        end

        // Brake release shows up one edge later, between step edges.
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        do_reset();
        wait_edges(4);
        check("brk_right_seq", 32'(Right), 32'h1);
        check("brk_left_on", 32'(Left), 32'h7);
        Brake = 1'b0;
        wait_edges(1);
        $display("brake drop: Left=%b Right=%b Tick=%b", Left, Right, Tick);
        check("brk_left_off", 32'(Left), 32'h0);
        check("brk_right_hold", 32'(Right), 32'h1);
        check("brk_tick_low", 32'(Tick), 32'h0);

        // TurnLeft dropped at 011; a short TurnRight pulse between ticks is ignored.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        wait_edges(8);
        check("drop_left_011", 32'(Left), 32'h3);
        TurnLeft = 1'b0;
        wait_edges(1);
        TurnRight = 1'b1;
        wait_edges(2);
        check("pulse_left_hold", 32'(Left), 32'h3);
        check("pulse_right_none", 32'(Right), 32'h0);
        TurnRight = 1'b0;
        wait_edges(1);
        $display("turn drop: Left=%b Right=%b Tick=%b", Left, Right, Tick);
        check("drop_left_idle", 32'(Left), 32'h0);
        check("drop_right_idle", 32'(Right), 32'h0);
        check("drop_tick", 32'(Tick), 32'h1);
        wait_edges(4);
        check("idle_stays_left", 32'(Left), 32'h0);
        check("idle_stays_right", 32'(Right), 32'h0);

        // Reset mid-sequence, then restart with TurnLeft held.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        wait_edges(8);
        check("mid_left_011", 32'(Left), 32'h3);
        wait_edges(1);
        RESET_n = 1'b0;
        wait_edges(1);
        check("mid_rst_left", 32'(Left), 32'h0);
        check("mid_rst_right", 32'(Right), 32'h0);
        check("mid_rst_tick", 32'(Tick), 32'h0);
        RESET_n = 1'b1;
        wait_edges(3);
        check("restart_wait_left", 32'(Left), 32'h0);
        check("restart_wait_tick", 32'(Tick), 32'h0);
        wait_edges(1);
        $display("restart: Left=%b Right=%b Tick=%b", Left, Right, Tick);
        check("restart_left", 32'(Left), 32'h1);
        check("restart_tick", 32'(Tick), 32'h1);

        // LAMPS=5, TICK_DIV=1: one animation step per clock.
        tl5 = 1'b1;
        wait_edges(1);
        check("l5_reset_left", 32'(Left5), 32'h0);
        check("l5_reset_tick", 32'(Tick5), 32'h0);
        rst5_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic [4:0] e5;
            int         ph;
            ph = i % 6;
            e5 = 5'b0;
            for (int b = 0; b < 5; b++) begin
                if (b <= ph && ph < 5) e5[b] = 1'b1;
            end
            wait_edges(1);
            $display("l5 cycle %0d: Left=%b Right=%b Tick=%b", i, Left5, Right5, Tick5);
            check($sformatf("l5_left_%0d", i), 32'(Left5), 32'(e5));
            check($sformatf("l5_right_%0d", i), 32'(Right5), 32'h0);
            check($sformatf("l5_tick_%0d", i), 32'(Tick5), 32'h1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/thunderbird_lights_seq.md
Name: thunderbird_lights_seq

Overview:
- Parametrised successor to the lab-4 ThunderBird turn-light FSM.
- Drives LAMPS lamps per side with sequential left/right turn animation, hazard flashing and brake override.
- An internal prescaler sets the animation step rate.
- Sits between driver-control inputs and the lamp drivers.

Parameters:
LAMPS, 3, lamps per side (>=2); bit 0 is the innermost lamp (La/Ra), bit LAMPS-1 the outermost.
TICK_DIV, 4, clk cycles per animation step (>=1); 1 steps every cycle.

Ports:
clk  in  1  system clock, rising edge.
RESET_n  in  1  synchronous active-low reset.
TurnLeft  in  1  left turn request, level.
TurnRight  in  1  right turn request, level.
Hazard  in  1  hazard request, level.
Brake  in  1  brake pedal, level.
Left  out  LAMPS  left lamp bank, registered.
Right  out  LAMPS  right lamp bank, registered.
Tick  out  1  registered one-cycle strobe marking each animation step.

Behaviour:
- Reset: while RESET_n=0 at a rising edge, the following hold after that edge:
  - state=IDLE, prescaler=0, Left=0, Right=0, Tick=0.
  - Reset mid-sequence aborts immediately; there is no partial animation.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick_int=1 when count==TICK_DIV-1.
  - Tick is registered from tick_int, so it is high in the cycle after the step edge.
  - After reset release, the first step edge is the TICK_DIV-th rising edge.
- States: IDLE, LEFT(k), RIGHT(k) for k=1..LAMPS, HAZ_ON, HAZ_OFF.
  - The state changes only on edges where tick_int=1.
  - Inputs are sampled only on those edges; pulses between ticks are ignored.
- Let haz = Hazard | (TurnLeft & TurnRight).
- Transitions on a tick, evaluated in priority order:
  - IDLE, HAZ_OFF: haz -> HAZ_ON; TurnLeft -> LEFT(1); TurnRight -> RIGHT(1); else IDLE.
  - LEFT(k): haz -> HAZ_ON; !TurnLeft -> IDLE; k<LAMPS -> LEFT(k+1); k==LAMPS -> IDLE.
  - RIGHT(k): symmetric to LEFT(k), using TurnRight.
  - HAZ_ON: always -> HAZ_OFF.
- Animation periods:
  - A held turn request gives a period of LAMPS+1 ticks (all-off gap included).
  - A held hazard gives a period of 2 ticks.
- Lamp decode, registered every clk edge from next_state and the current Brake:
  - LEFT(k): Left = low k bits set (e.g. LAMPS=3, k=2 -> 3'b011); Right = Brake ? all-ones : 0.
  - RIGHT(k): mirror of LEFT(k).
  - IDLE, HAZ_OFF: Left = Right = Brake ? all-ones : 0.
  - HAZ_ON: Left = Right = all-ones; Brake has no visible effect.
- Latency:
  - A Brake change appears on the lamps 1 edge later, independent of tick.
  - A turn/hazard change appears at the first step edge that samples it.
- Simultaneous TurnLeft and TurnRight is treated as a hazard (legacy lab behaviour).
- Switching direction mid-sequence passes through IDLE for one tick.
- TICK_DIV=1: the prescaler is constant, tick_int=1 every cycle, and the counter width is at least 1 bit.

Decomposition:
- Package thunderbird_pkg holds:
  - a state enum typedef (IDLE, SEQ_L, SEQ_R, HAZ_ON, HAZ_OFF);
  - a step-index width function ($clog2(LAMPS+1));
  - a thermometer-decode function (k -> low-k-ones mask).
- The state is encoded as enum plus a separate step counter k.
- Sub-module tick_prescaler (parameter TICK_DIV; ports clk, RESET_n, tick) generates tick_int.

Test Plan:
- Use LAMPS=3 and TICK_DIV=4 unless stated.
- Reset, then TurnLeft=1 held: Left steps 001, 011, 111, 000, 001 on successive step edges (every 4 cycles); Right=000 throughout.
- TurnRight=1 and Brake=1 held: Right sequences 001/011/111/000; Left=111 steady; dropping Brake clears Left 1 cycle later.
- TurnLeft and TurnRight both 1, or Hazard=1: Left=Right alternate 111/000 every tick; Brake=1 during HAZ_ON shows no change.
- TurnLeft dropped while Left=011: the next step edge gives Left=000 and state IDLE; a TurnRight pulse of 2 cycles between ticks produces no lamp change.
- RESET_n=0 for 1 edge while Left=011: Left=Right=000 and Tick=0 after that edge; with TurnLeft held, the animation restarts at 001 exactly 4 edges after release.
- LAMPS=5, TICK_DIV=1, TurnLeft held: Left = 00001, 00011, 00111, 01111, 11111, 00000 on consecutive cycles, repeating.
